multdiv_unit: RTL
=================

# multdiv_unit

Multicycle signed multiply/divide engine with its own sequencing FSM, sitting beside the main ALU in the multicycle CPU datapath. It serves the R-type `mult` and `div` instructions and the divide-by-zero exception path. The main control FSM issues a one-cycle start, stalls on `busy`, and reads the HI/LO results once `done` pulses. Operands come from the A/B register outputs, and results feed the `mfhi`/`mflo` paths of the MemToReg mux.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits.
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start_mult` input 1: one-cycle request for signed multiply of `a` × `b`.
- `start_div` input 1: one-cycle request for signed divide `a` / `b`.
- `a` input WIDTH: operand A (multiplicand or dividend). Sampled only on the accepting edge.
- `b` input WIDTH: operand B (multiplier or divisor). Sampled only on the accepting edge.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse; `hi`/`lo` hold the new result in the same cycle.
- `divby0` output 1: one-cycle pulse when a divide is requested with `b == 0`.
- `hi` output WIDTH: HI register (product upper half, or remainder).
- `lo` output WIDTH: LO register (product lower half, or quotient).

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: iterating; a 5-bit counter counts 0..31.
  - FIN: sign fix-up and result write.
- IDLE transitions:
  - `start_mult` → latch `a` and `b`, clear the partial accumulator, go to RUN.
  - `start_div` with `b != 0` → latch the absolute values and the operand signs, go to RUN.
  - `start_div` with `b == 0` → pulse `divby0`, stay in IDLE, leave `hi`/`lo` unchanged.
  - `start_mult` and `start_div` asserted together → multiply wins; the divide request is dropped.
- RUN, multiply: radix-2 Booth, one step per cycle.
  - Examine {Q[0], Q₋₁}: on 01 add M, on 10 subtract M.
  - Then arithmetic right shift of {Acc, Q, Q₋₁}.
- RUN, divide: restoring division on magnitudes, one quotient bit per cycle.
- RUN exits to FIN after the step with counter == 31, i.e. after exactly 32 steps.
- FIN:
  - Multiply: `hi` = Acc, `lo` = Q, giving the full 64-bit signed product.
  - Divide: `lo` = quotient truncated toward zero; `hi` = remainder carrying the sign of the dividend.
  - In both cases, pulse `done` and go to IDLE.
- Divide special case −2^31 / −1: `lo` = 0x80000000, `hi` = 0. No flag is raised; the overflow is silent, as MIPS specifies.
- Start requests arriving while `busy` is high are ignored: no queueing, no effect on the operation in flight.
- `hi`/`lo` change only in FIN or on reset. They hold their value across `divby0` and ignored starts.

## Timing
- Reset values: state IDLE, counter 0, `busy` 0, `done` 0, `divby0` 0, `hi` 0, `lo` 0.
- Reset asserted mid-operation aborts on that edge:
  - All outputs return to their reset values.
  - A start asserted in the same cycle as reset is ignored.
- Latency for a start high in cycle t:
  - `busy` is high in cycles t+1 through t+33.
  - `done` is high in cycle t+34 only, with `hi`/`lo` valid from t+34 onward.
  - `busy` is low in cycle t+34.
- A new start may be asserted in cycle t+34 and is accepted. Back-to-back throughput is one operation per 34 cycles.
- Divide by zero: start in cycle t → `divby0` is high in cycle t+1 only. `busy` never rises and `done` never pulses.
- `done` and `divby0` are never high in the same cycle.

## Test plan
- Reset, then `start_mult` with a=7, b=−3 → `busy` high for 33 cycles, then `done` high for exactly one cycle with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- `start_mult` with a=0x80000000, b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000. Then `start_div` with a=−7, b=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- `start_div` with a=100, b=0 → `divby0` high in cycle t+1 only. `busy` stays 0, and `hi`/`lo` keep their previous values.
- `start_div` with a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `done` at t+34. Also drive `start_mult` in cycle t+10 with different operands → ignored; result unchanged.
- `start_mult` and `start_div` together with a=6, b=4 → multiply executes: `lo`=24, `hi`=0.
- `start_mult` with a=5, b=5, then `reset` at cycle t+15 → in cycle t+16, `busy`=0 and `hi`=`lo`=0, and no `done` pulse follows. A new multiply afterwards completes normally with `lo`=25.

Source files
------------

// File: rtl/multdiv_unit.sv
// Multicycle signed multiply (radix-2 Booth) and restoring divide engine.
// 32 iteration steps, then a fix-up/write cycle; HI/LO registers hold the last result.
module multdiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divby0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    // One extra accumulator bit so that subtracting M = -2^(W-1) cannot overflow.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic             q_m1;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   div_r;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] fin_hi;
    logic [WIDTH-1:0] fin_lo;

    always_comb begin
        m_ext = {m[WIDTH-1], m};
        case ({q[0], q_m1})
            2'b01:   booth_sum = acc + m_ext;
            2'b10:   booth_sum = acc - m_ext;
            default: booth_sum = acc;
        endcase
        // Remainder stays below the divisor magnitude, so its low WIDTH bits suffice.
        div_r    = {acc[WIDTH-1:0], q[WIDTH-1]};
        div_diff = div_r - {1'b0, m};
        a_mag    = a[WIDTH-1] ? -a : a;
        b_mag    = b[WIDTH-1] ? -b : b;
        if (is_div) begin
            fin_lo = neg_q ? -q : q;
            fin_hi = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        end else begin
            fin_lo = q;
            fin_hi = acc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StIdle;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            q_m1   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            divby0 <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done   <= 1'b0;
            divby0 <= 1'b0;
            case (state)
                StIdle: begin
                    if (start_mult) begin
                        m      <= a;
                        q      <= b;
                        acc    <= '0;
                        q_m1   <= 1'b0;
                        is_div <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= StRun;
                    end else if (start_div) begin
                        if (b == '0) begin
                            divby0 <= 1'b1;
                        end else begin
                            m      <= b_mag;
                            q      <= a_mag;
                            acc    <= '0;
                            q_m1   <= 1'b0;
                            is_div <= 1'b1;
                            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r  <= a[WIDTH-1];
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (is_div) begin
                        if (!div_diff[WIDTH]) begin
                            acc <= div_diff;
                            q   <= {q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= div_r;
                            q   <= {q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc  <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                        q    <= {booth_sum[0], q[WIDTH-1:1]};
                        q_m1 <= q[0];
                    end
                    if (cnt == LastCnt) begin
                        cnt   <= '0;
                        state <= StFin;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StFin: begin
                    hi    <= fin_hi;
                    lo    <= fin_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
